// File: rtl/ga_pkg.sv
// ga_pkg: shared constants for the Gate Array sync and interrupt stage.
package ga_pkg;
    localparam int GA_HSYNC_DELAY    = 2;
    localparam int GA_HSYNC_MAXW     = 4;
    localparam int GA_VSYNC_LINES    = 26;
    localparam int GA_INT_LINES      = 52;
    localparam int GA_RMR_MODE_LSB   = 0;
    localparam int GA_RMR_INTRST_BIT = 4;
    typedef logic [1:0] ga_mode_t;
endpackage

// File: rtl/ga_int_counter.sv
// ga_int_counter: 52-line raster interrupt counter with VSYNC resynchronisation.
module ga_int_counter
    import ga_pkg::*;
#(
    parameter int INT_LINES = GA_INT_LINES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hs_fall,
    input  logic       i_vs_rise,
    input  logic       i_int_ack,
    input  logic       i_int_rst,
    output logic       o_int,
    output logic [5:0] o_r52
);
    localparam logic [5:0] LAST = 6'(INT_LINES - 1);
    logic [1:0] r_vsd;
    logic [5:0] w_base;
    logic       w_resync;
    assign w_base   = i_int_ack ? {1'b0, o_r52[4:0]} : o_r52;
    assign w_resync = i_hs_fall && r_vsd == 2'd1;
    // A wrap always wins, so an acknowledge on the wrapping line still raises INT
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r52 <= '0;
            o_int <= 1'b0;
            r_vsd <= '0;
        end else begin
            r_vsd <= i_vs_rise ? 2'd2 : (i_hs_fall && r_vsd != 2'd0) ? r_vsd - 2'd1 : r_vsd;
            if (i_int_rst) begin
                o_r52 <= '0;
                o_int <= 1'b0;
            end else if (w_resync) begin
                o_r52 <= '0;
                o_int <= o_r52[5] | (o_int & ~i_int_ack);
            end else if (i_hs_fall && o_r52 == LAST) begin
                o_r52 <= '0;
                o_int <= 1'b1;
            end else begin
                o_r52 <= i_hs_fall ? w_base + 6'd1 : w_base;
                o_int <= o_int & ~i_int_ack;
            end
        end
    end
endmodule

// File: rtl/ga_sync_int.sv
// ga_sync_int: Gate Array sync shaping, raster interrupt and screen mode latch.
// GA_MODE_LATCH_EN defers RMR mode writes to the next HSYNC rise.
module ga_sync_int
    import ga_pkg::*;
#(
    parameter int HSYNC_DELAY = GA_HSYNC_DELAY,
    parameter int HSYNC_MAXW  = GA_HSYNC_MAXW,
    parameter int VSYNC_LINES = GA_VSYNC_LINES,
    parameter int INT_LINES   = GA_INT_LINES
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CLKEN,
    input  logic       HSYNC_IN,
    input  logic       VSYNC_IN,
    input  logic       INT_ACK,
    input  logic       RMR_WR,
    input  logic [7:0] RMR_DI,
    output logic       INT,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic [1:0] MODE,
    output logic [5:0] R52
);
    localparam logic [4:0] H_ON  = 5'(HSYNC_DELAY);
    localparam logic [4:0] H_OFF = 5'(HSYNC_DELAY + HSYNC_MAXW);
    localparam int VW = $clog2(VSYNC_LINES + 1);
    localparam logic [VW-1:0] V_LOAD = VW'(VSYNC_LINES);
    logic          r_hs, r_vs;
    logic [3:0]    r_hcnt;
    logic [VW-1:0] r_vcnt, w_vcnt_nxt;
    logic          w_hs_fall, w_vs_rise, w_unused;
    assign w_hs_fall  = CLKEN && r_hs && !HSYNC_IN;
    assign w_vs_rise  = CLKEN && !r_vs && VSYNC_IN;
    assign w_vcnt_nxt = w_vs_rise ? V_LOAD : (w_hs_fall && r_vcnt != '0) ? r_vcnt - VW'(1) : r_vcnt;
    assign w_unused   = ^{RMR_DI[7:5], RMR_DI[3:2]};
    // HSYNC_OUT looks at the settled count so short CRTC pulses never leak through
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            HSYNC_OUT <= 1'b0;
            VSYNC_OUT <= 1'b0;
        end else begin
            r_hs      <= CLKEN ? HSYNC_IN : r_hs;
            r_vs      <= CLKEN ? VSYNC_IN : r_vs;
            r_hcnt    <= !HSYNC_IN ? 4'd0 : (CLKEN && r_hcnt != 4'hf) ? r_hcnt + 4'd1 : r_hcnt;
            r_vcnt    <= w_vcnt_nxt;
            HSYNC_OUT <= HSYNC_IN && {1'b0, r_hcnt} >= H_ON && {1'b0, r_hcnt} < H_OFF;
            VSYNC_OUT <= VSYNC_IN && w_vcnt_nxt != '0;
        end
    end
`ifdef GA_MODE_LATCH_EN
    logic [1:0] r_pend;
    logic       w_hs_rise;
    assign w_hs_rise = CLKEN && !r_hs && HSYNC_IN;
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pend <= '0;
            MODE   <= '0;
        end else begin
            r_pend <= RMR_WR ? RMR_DI[GA_RMR_MODE_LSB +: 2] : r_pend;
            MODE   <= w_hs_rise ? r_pend : MODE;
        end
    end
`else
    always_ff @(posedge CLOCK) begin
        if (RESET) MODE <= '0;
        else MODE <= RMR_WR ? RMR_DI[GA_RMR_MODE_LSB +: 2] : MODE;
    end
`endif
    ga_int_counter #(.INT_LINES(INT_LINES)) u_cnt (
        .clk       (CLOCK),
        .rst       (RESET),
        .i_hs_fall (w_hs_fall),
        .i_vs_rise (w_vs_rise),
        .i_int_ack (INT_ACK),
        .i_int_rst (RMR_WR && RMR_DI[GA_RMR_INTRST_BIT]),
        .o_int     (INT),
        .o_r52     (R52)
    );
endmodule

// File: tb/tb_ga_sync_int.sv
// tb_ga_sync_int: self-checking bench for ga_sync_int with a behavioural reference model.
module tb_ga_sync_int;
    import ga_pkg::*;
    logic       CLOCK = 1'b0;
    logic       RESET, CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, RMR_WR;
    logic [7:0] RMR_DI;
    logic       INT, HSYNC_OUT, VSYNC_OUT;
    logic [1:0] MODE;
    logic [5:0] R52;
    int n_vec = 0, n_mis = 0, hcount = 0, guard;
    bit rnd = 0;
    int m_line, m_vleft, m_vsd, m_hlen, m_mode, m_pend;
    bit m_int, m_hso, m_vso, m_hsp, m_vsp;
    typedef struct { int w; int exp_clk; } hs_vec_t;
    hs_vec_t hv[7];

    ga_sync_int dut (
        .CLOCK(CLOCK), .RESET(RESET), .CLKEN(CLKEN), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .INT_ACK(INT_ACK), .RMR_WR(RMR_WR), .RMR_DI(RMR_DI), .INT(INT), .HSYNC_OUT(HSYNC_OUT),
        .VSYNC_OUT(VSYNC_OUT), .MODE(MODE), .R52(R52)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference: one CLOCK of the spec's rules in plain integer arithmetic
    task automatic model_step();
        bit hfall, vrise, hrise;
        int l;
        bit i;
        if (RESET) begin
            m_line = 0; m_int = 0; m_vleft = 0; m_vsd = 0; m_hlen = 0; m_mode = 0; m_pend = 0;
            m_hso = 0; m_vso = 0; m_hsp = 0; m_vsp = 0;
            return;
        end
        hfall = CLKEN && m_hsp && !HSYNC_IN;
        vrise = CLKEN && !m_vsp && VSYNC_IN;
        hrise = CLKEN && !m_hsp && HSYNC_IN;
        m_hso = HSYNC_IN && m_hlen >= GA_HSYNC_DELAY && m_hlen < GA_HSYNC_DELAY + GA_HSYNC_MAXW;
        m_hlen = !HSYNC_IN ? 0 : CLKEN ? (m_hlen < 15 ? m_hlen + 1 : 15) : m_hlen;
        if (vrise) m_vleft = GA_VSYNC_LINES;
        else if (hfall && m_vleft > 0) m_vleft--;
        m_vso = VSYNC_IN && m_vleft != 0;
        if (RMR_WR && RMR_DI[4]) begin
            m_line = 0; m_int = 0;
        end else if (hfall && m_vsd == 1) begin
            m_int = (m_line >= 32) || (m_int && !INT_ACK);
            m_line = 0;
        end else begin
            l = INT_ACK ? m_line % 32 : m_line;
            i = m_int && !INT_ACK;
            if (hfall && m_line + 1 == GA_INT_LINES) begin l = 0; i = 1; end
            else if (hfall) l++;
            m_line = l; m_int = i;
        end
        if (vrise) m_vsd = 2;
        else if (hfall && m_vsd > 0) m_vsd--;
`ifdef GA_MODE_LATCH_EN
        if (hrise) m_mode = m_pend;
        if (RMR_WR) m_pend = int'(RMR_DI[1:0]);
`else
        if (RMR_WR) m_mode = int'(RMR_DI[1:0]);
`endif
        if (CLKEN) begin m_hsp = HSYNC_IN; m_vsp = VSYNC_IN; end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        #1;
        if (HSYNC_OUT === 1'b1) hcount++;
        chk("INT", 8'(INT), 8'(m_int));
        chk("R52", 8'(R52), 8'(m_line));
        chk("HSYNC_OUT", 8'(HSYNC_OUT), 8'(m_hso));
        chk("VSYNC_OUT", 8'(VSYNC_OUT), 8'(m_vso));
        chk("MODE", 8'(MODE), 8'(m_mode));
    endtask

    task automatic chr(input logic hs, input logic vs, input logic ack_en = 1'b0);
        HSYNC_IN = hs;
        VSYNC_IN = vs;
        for (int c = 0; c < 4; c++) begin
            CLKEN   = (c == 3);
            INT_ACK = (c == 3 && ack_en) || (rnd && $urandom_range(0, 15) == 0);
            RMR_WR  = rnd && $urandom_range(0, 23) == 0;
            RMR_DI  = 8'($urandom);
            tick();
        end
        CLKEN = 0; INT_ACK = 0; RMR_WR = 0;
    endtask

    task automatic pulse(input logic ack, input logic wr, input logic [7:0] di);
        INT_ACK = ack; RMR_WR = wr; RMR_DI = di;
        tick();
        INT_ACK = 0; RMR_WR = 0;
    endtask

    task automatic line(input logic vs, input int n = 1);
        repeat (n) begin
            repeat (4) chr(1'b1, vs);
            repeat (4) chr(1'b0, vs);
        end
    endtask

    initial begin
        hv[0] = '{14, 16}; hv[1] = '{2, 0}; hv[2] = '{1, 0}; hv[3] = '{3, 4};
        hv[4] = '{4, 8};   hv[5] = '{6, 16}; hv[6] = '{5, 12};
        RESET = 1; CLKEN = 0; HSYNC_IN = 0; VSYNC_IN = 0; INT_ACK = 0; RMR_WR = 0; RMR_DI = 0;
        tick(); tick();
        RESET = 0;
        chk("rst_int", 8'(INT), 8'd0);
        chk("rst_r52", 8'(R52), 8'd0);
        chk("rst_mode", 8'(MODE), 8'd0);
        chk("rst_hso", 8'(HSYNC_OUT), 8'd0);
        chk("rst_vso", 8'(VSYNC_OUT), 8'd0);
        // 52 lines raise the interrupt
        line(0, 51);
        chk("r52_51", 8'(R52), 8'd51);
        chk("int_pre52", 8'(INT), 8'd0);
        line(0);
        chk("int_52", 8'(INT), 8'd1);
        chk("r52_wrap", 8'(R52), 8'd0);
        pulse(1, 0, 8'h00);
        chk("int_ack", 8'(INT), 8'd0);
        // VSYNC resync with bit 5 set and clear
        line(0, 40);
        chk("r52_40", 8'(R52), 8'd40);
        line(1, 2);
        chk("rs40_r52", 8'(R52), 8'd0);
        chk("rs40_int", 8'(INT), 8'd1);
        pulse(1, 0, 8'h00);
        line(0, 20);
        chk("r52_20", 8'(R52), 8'd20);
        line(1, 2);
        chk("rs20_r52", 8'(R52), 8'd0);
        chk("rs20_int", 8'(INT), 8'd0);
        // RMR interrupt reset and mode write
        line(0, 52);
        line(0, 30);
        chk("r52_30", 8'(R52), 8'd30);
        chk("int_30", 8'(INT), 8'd1);
        pulse(0, 1, 8'h12);
        chk("rmr_int", 8'(INT), 8'd0);
        chk("rmr_r52", 8'(R52), 8'd0);
`ifdef GA_MODE_LATCH_EN
        chk("mode_pending", 8'(MODE), 8'd0);
`else
        chk("mode_direct", 8'(MODE), 8'd2);
`endif
        line(0);
        chk("mode_line", 8'(MODE), 8'd2);
        // Monitor HSYNC width table
        for (int k = 0; k < 7; k++) begin
            hcount = 0;
            repeat (hv[k].w) chr(1'b1, 1'b0);
            repeat (3) chr(1'b0, 1'b0);
            chk($sformatf("hs_width_%0d", hv[k].w), 8'(hcount), 8'(hv[k].exp_clk));
        end
        // VSYNC shorter than the limit, then longer
        chr(0, 1);
        chk("vso_rise", 8'(VSYNC_OUT), 8'd1);
        line(1, 16);
        chk("vso16_on", 8'(VSYNC_OUT), 8'd1);
        chr(0, 0);
        chk("vso16_off", 8'(VSYNC_OUT), 8'd0);
        chr(0, 1);
        line(1, 25);
        chk("vso32_25", 8'(VSYNC_OUT), 8'd1);
        line(1);
        chk("vso32_26", 8'(VSYNC_OUT), 8'd0);
        line(1, 6);
        chk("vso32_32", 8'(VSYNC_OUT), 8'd0);
        chr(0, 0);
        // INT_ACK on the hs_fall that reaches 52
        guard = 0;
        while (m_line != 51 && guard < 60) begin line(0); guard++; end
        chk("reach51", 8'(R52), 8'd51);
        repeat (4) chr(1, 0);
        chr(0, 0, 1'b1);
        chk("ackwrap_int", 8'(INT), 8'd1);
        chk("ackwrap_r52", 8'(R52), 8'd0);
        // RESET mid-frame with a resync pending
        line(0, 10);
        chr(0, 1);
        repeat (3) chr(1, 1);
        RESET = 1;
        tick();
        RESET = 0;
        chk("mrst_int", 8'(INT), 8'd0);
        chk("mrst_r52", 8'(R52), 8'd0);
        chk("mrst_hso", 8'(HSYNC_OUT), 8'd0);
        chk("mrst_vso", 8'(VSYNC_OUT), 8'd0);
        chk("mrst_mode", 8'(MODE), 8'd0);
        line(0, 3);
        chk("mrst_noresync", 8'(R52), 8'd3);
        // Randomised lines with random acknowledges and RMR writes
        rnd = 1;
        for (int n = 0; n < 150; n++) begin
            automatic int hw = $urandom_range(1, 12);
            automatic int lw = $urandom_range(1, 6);
            automatic logic vs = VSYNC_IN ^ ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin RESET = 1; tick(); RESET = 0; end
            repeat (hw) chr(1'b1, vs);
            repeat (lw) chr(1'b0, vs);
        end
        rnd = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end
endmodule
